// File: rtl/fpu_pipe_pkg.sv
// Shared types and helpers for the FPU pipeline sequencer.
// The stats-build macro FPU_PIPE_STATS_EN is consumed by the files that import this package.
package fpu_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } pipe_state_t;

    // Record layout of one stage at the default tag and timestamp widths.
    localparam int unsigned SLOT_TAG_W = 4;
    localparam int unsigned SLOT_TS_W  = 8;

    typedef struct packed {
        logic                  vld;
        logic [SLOT_TAG_W-1:0] tag;
        logic [SLOT_TS_W-1:0]  ts;
    } slot_t;

    function automatic int unsigned clog2p1(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fpu_pipe_slot.sv
// One pipeline stage's bookkeeping: valid bit, op tag and (FPU_PIPE_STATS_EN) entry timestamp.
// Loads on load, drops its op when it moves on, clears valid on flush and everything on RST.
module fpu_pipe_slot
    import fpu_pipe_pkg::*;
#(
    parameter int unsigned TAG_W = 4
`ifdef FPU_PIPE_STATS_EN
    ,
    parameter int unsigned CNT_W = 8
`endif
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             flush,
    input  logic             load,
    input  logic             move,
    input  logic [TAG_W-1:0] tag_in,
`ifdef FPU_PIPE_STATS_EN
    input  logic [CNT_W-1:0] ts_in,
    output logic [CNT_W-1:0] ts,
`endif
    output logic             vld,
    output logic [TAG_W-1:0] tag
);

    always_ff @(posedge CK) begin
        if (RST) begin
            vld <= 1'b0;
            tag <= '0;
        end else begin
            vld <= ~flush & (load | (vld & ~move));
            if (load) begin
                tag <= tag_in;
            end
        end
    end

`ifdef FPU_PIPE_STATS_EN
    always_ff @(posedge CK) begin
        if (RST) begin
            ts <= '0;
        end else if (load) begin
            ts <= ts_in;
        end
    end
`endif

endmodule

// File: rtl/fpu_pipe_ctrl.sv
// Valid/ready sequencer for the STAGES-deep FPU datapath with bubble collapse and flush.
// Define FPU_PIPE_STATS_EN to add the latency/throughput statistics counters.
module fpu_pipe_ctrl
    import fpu_pipe_pkg::*;
#(
    parameter int unsigned STAGES = 4,
    parameter int unsigned TAG_W  = 4
`ifdef FPU_PIPE_STATS_EN
    ,
    parameter int unsigned CNT_W  = 8
`endif
) (
    input  logic                          CK,
    input  logic                          RST,
    input  logic                          in_valid,
    input  logic [TAG_W-1:0]              in_tag,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [TAG_W-1:0]              out_tag,
    input  logic                          out_ready,
    input  logic                          flush,
    output logic [STAGES-1:0]             stage_en,
    output logic [STAGES-1:0]             stage_vld,
    output logic [clog2p1(STAGES)-1:0]    inflight,
    output logic                          busy
`ifdef FPU_PIPE_STATS_EN
    ,
    output logic [CNT_W-1:0]              lat_max,
    output logic [CNT_W-1:0]              ops_done
`endif
);

    localparam int unsigned L  = STAGES - 1;
    localparam int unsigned IW = clog2p1(STAGES);

    pipe_state_t       state;
    logic              accept;
    logic              move [STAGES];
    logic [TAG_W-1:0]  tag  [STAGES];
    logic [STAGES-1:0] vld_nxt;

`ifdef FPU_PIPE_STATS_EN
    logic [CNT_W-1:0]  now;
    logic [CNT_W-1:0]  ts   [STAGES];
    logic [CNT_W-1:0]  lat;
`endif

    assign in_ready  = (~stage_vld[0] | move[0]) & (state != FLUSH) & ~RST;
    assign accept    = in_valid & in_ready;
    assign out_valid = stage_vld[L];
    assign out_tag   = tag[L];
    assign inflight  = IW'($countones(stage_vld));

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        // A stage advances when the next one is empty or advancing itself.
        if (i == L) begin : g_last
            assign move[i] = stage_vld[i] & out_ready;
        end else begin : g_mid
            assign move[i] = stage_vld[i] & (~stage_vld[i+1] | move[i+1]);
        end

        if (i == 0) begin : g_first
            assign stage_en[i] = accept & ~flush;
        end else begin : g_rest
            assign stage_en[i] = move[i-1] & ~flush;
        end

        assign vld_nxt[i] = stage_en[i] | (stage_vld[i] & ~move[i]);

        fpu_pipe_slot #(
            .TAG_W (TAG_W)
`ifdef FPU_PIPE_STATS_EN
            ,
            .CNT_W (CNT_W)
`endif
        ) u_slot (
            .CK     (CK),
            .RST    (RST),
            .flush  (flush),
            .load   (stage_en[i]),
            .move   (move[i]),
            .tag_in ((i == 0) ? in_tag : tag[(i == 0) ? 0 : i-1]),
`ifdef FPU_PIPE_STATS_EN
            .ts_in  ((i == 0) ? now : ts[(i == 0) ? 0 : i-1]),
            .ts     (ts[i]),
`endif
            .vld    (stage_vld[i]),
            .tag    (tag[i])
        );
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else if (flush) begin
            state <= FLUSH;
            busy  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (vld_nxt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FPU_PIPE_STATS_EN
    // Modular difference keeps the latency correct across counter wrap.
    assign lat = now - ts[L];

    always_ff @(posedge CK) begin
        if (RST) begin
            now      <= '0;
            lat_max  <= '0;
            ops_done <= '0;
        end else begin
            now <= now + 1'b1;
            if (out_valid & out_ready) begin
                if (lat > lat_max) begin
                    lat_max <= lat;
                end
                if (ops_done != '1) begin
                    ops_done <= ops_done + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fpu_pipe_ctrl.sv
// Directed vector bench for fpu_pipe_ctrl (STAGES=4, TAG_W=4); stats checks under FPU_PIPE_STATS_EN.
module tb_fpu_pipe_ctrl;

    typedef struct {
        logic       rst;
        logic       in_valid;
        logic [3:0] in_tag;
        logic       out_ready;
        logic       flush;
        logic       e_rdy;
        logic       e_ov;
        logic [3:0] e_tag;
        logic [3:0] e_vld;
        logic [3:0] e_en;
        logic [2:0] e_inf;
        logic       e_busy;
    } vec_t;

    logic       CK = 1'b0;
    logic       RST;
    logic       in_valid;
    logic [3:0] in_tag;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_tag;
    logic       out_ready;
    logic       flush;
    logic [3:0] stage_en;
    logic [3:0] stage_vld;
    logic [2:0] inflight;
    logic       busy;
`ifdef FPU_PIPE_STATS_EN
    logic [7:0] lat_max;
    logic [7:0] ops_done;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl[$];

    always #5 CK = ~CK;

    fpu_pipe_ctrl #(
        .STAGES (4),
        .TAG_W  (4)
    ) dut (
        .CK        (CK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_tag    (in_tag),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_tag   (out_tag),
        .out_ready (out_ready),
        .flush     (flush),
        .stage_en  (stage_en),
        .stage_vld (stage_vld),
        .inflight  (inflight),
        .busy      (busy)
`ifdef FPU_PIPE_STATS_EN
        ,
        .lat_max   (lat_max),
        .ops_done  (ops_done)
`endif
    );

    function automatic void add(input int r, input int iv, input int t, input int ordy,
                                input int fl, input int er, input int eov, input int et,
                                input int ev, input int een, input int einf, input int eb);
        vec_t x;
        x.rst = r[0];  x.in_valid = iv[0]; x.in_tag = t[3:0]; x.out_ready = ordy[0];
        x.flush = fl[0]; x.e_rdy = er[0]; x.e_ov = eov[0]; x.e_tag = et[3:0];
        x.e_vld = ev[3:0]; x.e_en = een[3:0]; x.e_inf = einf[2:0]; x.e_busy = eb[0];
        tbl.push_back(x);
    endfunction

    task automatic drive(input logic r, input logic iv, input logic [3:0] t,
                         input logic ordy, input logic fl);
        @(posedge CK);
        #1;
        RST = r; in_valid = iv; in_tag = t; out_ready = ordy; flush = fl;
        @(negedge CK);
    endtask

    task automatic check(input int idx, input vec_t v);
        logic ok;
        ok = (in_ready === v.e_rdy) && (out_valid === v.e_ov) && (stage_vld === v.e_vld) &&
             (stage_en === v.e_en) && (inflight === v.e_inf) && (busy === v.e_busy);
        if (v.e_ov || v.rst) ok = ok && (out_tag === v.e_tag);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL vec %0d: got rdy=%b ov=%b tag=%0d vld=%b en=%b inf=%0d busy=%b, want rdy=%b ov=%b tag=%0d vld=%b en=%b inf=%0d busy=%b",
                     idx, in_ready, out_valid, out_tag, stage_vld, stage_en, inflight, busy,
                     v.e_rdy, v.e_ov, v.e_tag, v.e_vld, v.e_en, v.e_inf, v.e_busy);
        end
    endtask

`ifdef FPU_PIPE_STATS_EN
    task automatic check_stat(input string name, input logic [7:0] e_lat, input logic [7:0] e_ops);
        n_vec++;
        if (lat_max !== e_lat || ops_done !== e_ops) begin
            n_err++;
            $display("FAIL %s: got lat_max=%0d ops_done=%0d, want lat_max=%0d ops_done=%0d",
                     name, lat_max, ops_done, e_lat, e_ops);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //   rst iv tag ordy fl | rdy ov tag vld     en      inf busy
        add(1, 0, 0, 1, 0,   0, 0, 0, 'b0000, 'b0000, 0, 0);
        // Full-rate stream, tags 0..7
        add(0, 1, 0, 1, 0,   1, 0, 0, 'b0000, 'b0001, 0, 0);
        add(0, 1, 1, 1, 0,   1, 0, 0, 'b0001, 'b0011, 1, 1);
        add(0, 1, 2, 1, 0,   1, 0, 0, 'b0011, 'b0111, 2, 1);
        add(0, 1, 3, 1, 0,   1, 0, 0, 'b0111, 'b1111, 3, 1);
        add(0, 1, 4, 1, 0,   1, 1, 0, 'b1111, 'b1111, 4, 1);
        add(0, 1, 5, 1, 0,   1, 1, 1, 'b1111, 'b1111, 4, 1);
        add(0, 1, 6, 1, 0,   1, 1, 2, 'b1111, 'b1111, 4, 1);
        add(0, 1, 7, 1, 0,   1, 1, 3, 'b1111, 'b1111, 4, 1);
        add(0, 0, 0, 1, 0,   1, 1, 4, 'b1111, 'b1110, 4, 1);
        add(0, 0, 0, 1, 0,   1, 1, 5, 'b1110, 'b1100, 3, 1);
        add(0, 0, 0, 1, 0,   1, 1, 6, 'b1100, 'b1000, 2, 1);
        add(0, 0, 0, 1, 0,   1, 1, 7, 'b1000, 'b0000, 1, 1);
        add(0, 0, 0, 1, 0,   1, 0, 0, 'b0000, 'b0000, 0, 0);
        // Fill then 5-cycle output stall, then drain
        add(0, 1, 8, 0, 0,   1, 0, 0, 'b0000, 'b0001, 0, 0);
        add(0, 1, 9, 0, 0,   1, 0, 0, 'b0001, 'b0011, 1, 1);
        add(0, 1, 10, 0, 0,  1, 0, 0, 'b0011, 'b0111, 2, 1);
        add(0, 1, 11, 0, 0,  1, 0, 0, 'b0111, 'b1111, 3, 1);
        for (int k = 0; k < 5; k++) add(0, 0, 0, 0, 0,  0, 1, 8, 'b1111, 'b0000, 4, 1);
        add(0, 0, 0, 1, 0,   1, 1, 8, 'b1111, 'b1110, 4, 1);
        add(0, 0, 0, 1, 0,   1, 1, 9, 'b1110, 'b1100, 3, 1);
        add(0, 0, 0, 1, 0,   1, 1, 10, 'b1100, 'b1000, 2, 1);
        add(0, 0, 0, 1, 0,   1, 1, 11, 'b1000, 'b0000, 1, 1);
        add(0, 0, 0, 1, 0,   1, 0, 0, 'b0000, 'b0000, 0, 0);
        // Bubble collapse behind a stalled op
        add(0, 1, 1, 1, 0,   1, 0, 0, 'b0000, 'b0001, 0, 0);
        add(0, 0, 0, 1, 0,   1, 0, 0, 'b0001, 'b0010, 1, 1);
        add(0, 1, 2, 1, 0,   1, 0, 0, 'b0010, 'b0101, 1, 1);
        add(0, 0, 0, 0, 0,   1, 0, 0, 'b0101, 'b1010, 2, 1);
        add(0, 0, 0, 0, 0,   1, 1, 1, 'b1010, 'b0100, 2, 1);
        add(0, 0, 0, 0, 0,   1, 1, 1, 'b1100, 'b0000, 2, 1);
        add(0, 0, 0, 0, 0,   1, 1, 1, 'b1100, 'b0000, 2, 1);
        add(0, 0, 0, 1, 0,   1, 1, 1, 'b1100, 'b1000, 2, 1);
        add(0, 0, 0, 1, 0,   1, 1, 2, 'b1000, 'b0000, 1, 1);
        add(0, 0, 0, 1, 0,   1, 0, 0, 'b0000, 'b0000, 0, 0);
        // Flush with a same-cycle issue, then back-to-back flush from IDLE
        add(0, 1, 3, 1, 0,   1, 0, 0, 'b0000, 'b0001, 0, 0);
        add(0, 1, 4, 1, 0,   1, 0, 0, 'b0001, 'b0011, 1, 1);
        add(0, 1, 5, 1, 0,   1, 0, 0, 'b0011, 'b0111, 2, 1);
        add(0, 1, 6, 1, 1,   1, 0, 0, 'b0111, 'b0000, 3, 1);
        add(0, 1, 7, 1, 0,   0, 0, 0, 'b0000, 'b0000, 0, 1);
        add(0, 1, 9, 1, 1,   1, 0, 0, 'b0000, 'b0000, 0, 0);
        add(0, 0, 0, 1, 1,   0, 0, 0, 'b0000, 'b0000, 0, 1);
        add(0, 0, 0, 1, 0,   0, 0, 0, 'b0000, 'b0000, 0, 1);
        add(0, 0, 0, 1, 0,   1, 0, 0, 'b0000, 'b0000, 0, 0);
        // Reset with four ops in flight
        add(0, 1, 12, 0, 0,  1, 0, 0, 'b0000, 'b0001, 0, 0);
        add(0, 1, 13, 0, 0,  1, 0, 0, 'b0001, 'b0011, 1, 1);
        add(0, 1, 14, 0, 0,  1, 0, 0, 'b0011, 'b0111, 2, 1);
        add(0, 1, 15, 0, 0,  1, 0, 0, 'b0111, 'b1111, 3, 1);
        add(1, 1, 0, 0, 0,   0, 1, 12, 'b1111, 'b0000, 4, 1);
        add(1, 0, 0, 1, 0,   0, 0, 0, 'b0000, 'b0000, 0, 0);
        add(0, 0, 0, 1, 0,   1, 0, 0, 'b0000, 'b0000, 0, 0);

        RST = 1'b1; in_valid = 1'b0; in_tag = '0; out_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge CK);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].in_valid, tbl[i].in_tag, tbl[i].out_ready, tbl[i].flush);
            check(i, tbl[i]);
        end

`ifdef FPU_PIPE_STATS_EN
        check_stat("stats after reset", 8'd0, 8'd0);
        drive(1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
        repeat (6) drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check_stat("stalled op", 8'd7, 8'd1);
        drive(1'b0, 1'b1, 4'd6, 1'b1, 1'b0);
        repeat (5) drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check_stat("unstalled op", 8'd7, 8'd2);
`endif

        // Alternating backpressure: six ops must leave in order, none lost or duplicated
        begin
            int sent;
            int got;
            sent = 0;
            got  = 0;
            for (int c = 0; c < 100 && got < 6; c++) begin
                @(posedge CK);
                #1;
                RST = 1'b0; flush = 1'b0; out_ready = c[0];
                in_valid = (sent < 6); in_tag = 4'(sent);
                @(negedge CK);
                if (in_valid && in_ready) sent++;
                if (out_valid && out_ready) begin
                    n_vec++;
                    if (out_tag !== 4'(got)) begin
                        n_err++;
                        $display("FAIL order: out_tag=%0d, want %0d", out_tag, got);
                    end
                    got++;
                end
            end
            n_vec++;
            if (got != 6) begin
                n_err++;
                $display("FAIL drain: %0d results seen within cycle budget, want 6", got);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
